// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings and constants for the instruction/data memory bus arbiter.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ArbIdle   = 2'd0,
        ArbAccess = 2'd1,
        ArbDone   = 2'd2
    } arb_state_e;

    typedef enum logic {
        OwnerIF  = 1'b0,
        OwnerMEM = 1'b1
    } owner_e;

    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam logic        RstEnable    = 1'b0;

endpackage

// File: rtl/mem_bus_watchdog.sv
// Access watchdog: counts ACCESS cycles and flags the last permitted wait cycle.
module mem_bus_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic timeout
);
    import mem_bus_arbiter_pkg::*;

    localparam int W = $clog2(TIMEOUT) + 1;
    localparam logic [W-1:0] LastCnt = W'(TIMEOUT - 1);

    logic [W-1:0] wd_cnt_q, wd_cnt_d;

    // Saturates at the last cycle so a held enable can never wrap back to zero.
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (clr) begin
            wd_cnt_d = '0;
        end else if (en && wd_cnt_q != LastCnt) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn == RstEnable) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end

    assign timeout = en && (wd_cnt_q == LastCnt);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-port memory bus arbiter between instruction fetch and the MEM stage.
// MEM has priority; IF is forced through after STARVE_LIMIT consecutive losses.
module mem_bus_arbiter #(
    parameter int TIMEOUT      = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        ram_req,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic        ram_ack,
    output logic        bus_err,
    output logic        stall_o
);
    import mem_bus_arbiter_pkg::*;

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] StarveMax = SW'(STARVE_LIMIT);

    arb_state_e    state_q, state_d;
    owner_e        owner_q, owner_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          ram_req_q, ram_req_d;
    logic          ram_we_q, ram_we_d;
    logic [31:0]   ram_addr_q, ram_addr_d;
    logic [31:0]   ram_wdata_q, ram_wdata_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   mem_rdata_q, mem_rdata_d;
    logic          if_ready_q, if_ready_d;
    logic          mem_ready_q, mem_ready_d;
    logic          bus_err_q, bus_err_d;

    logic wd_clr, wd_en, wd_timeout;
    logic pick_if;

    mem_bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (clk),
        .resetn (resetn),
        .clr    (wd_clr),
        .en     (wd_en),
        .timeout(wd_timeout)
    );

    assign pick_if = if_req && (!mem_req || starve_q == StarveMax);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        starve_d    = starve_q;
        ram_req_d   = ram_req_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;
        bus_err_d   = 1'b0;
        wd_clr      = 1'b0;
        wd_en       = 1'b0;

        unique case (state_q)
            ArbIdle: begin
                if (if_req || mem_req) begin
                    ram_req_d = 1'b1;
                    wd_clr    = 1'b1;
                    state_d   = ArbAccess;
                    if (pick_if) begin
                        owner_d     = OwnerIF;
                        ram_we_d    = WriteDisable;
                        ram_addr_d  = if_addr;
                        ram_wdata_d = ZeroWord;
                        starve_d    = '0;
                    end else begin
                        owner_d     = OwnerMEM;
                        ram_we_d    = mem_we ? WriteEnable : WriteDisable;
                        ram_addr_d  = mem_addr;
                        ram_wdata_d = mem_wdata;
                        if (if_req && starve_q != StarveMax) begin
                            starve_d = starve_q + 1'b1;
                        end
                    end
                end
            end
            ArbAccess: begin
                wd_en = 1'b1;
                // Ack is checked first so an ack on the final wait cycle still completes cleanly.
                if (ram_ack || wd_timeout) begin
                    ram_req_d = 1'b0;
                    state_d   = ArbDone;
                    bus_err_d = !ram_ack;
                    if (owner_q == OwnerIF) begin
                        if_ready_d = 1'b1;
                        if (!ram_ack) begin
                            if_rdata_d = ZeroWord;
                        end else if (ram_we_q == WriteDisable) begin
                            if_rdata_d = ram_rdata;
                        end
                    end else begin
                        mem_ready_d = 1'b1;
                        if (!ram_ack) begin
                            mem_rdata_d = ZeroWord;
                        end else if (ram_we_q == WriteDisable) begin
                            mem_rdata_d = ram_rdata;
                        end
                    end
                end
            end
            ArbDone: begin
                state_d = ArbIdle;
            end
            default: begin
                state_d = ArbIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetn == RstEnable) begin
            state_q     <= ArbIdle;
            owner_q     <= OwnerIF;
            starve_q    <= '0;
            ram_req_q   <= 1'b0;
            ram_we_q    <= WriteDisable;
            ram_addr_q  <= ZeroWord;
            ram_wdata_q <= ZeroWord;
            if_rdata_q  <= ZeroWord;
            mem_rdata_q <= ZeroWord;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            ram_req_q   <= ram_req_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_ready_q  <= if_ready_d;
            mem_ready_q <= mem_ready_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign ram_req   = ram_req_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign if_ready  = if_ready_q;
    assign mem_ready = mem_ready_q;
    assign bus_err   = bus_err_q;
    assign stall_o   = (if_req && !if_ready_q) || (mem_req && !mem_ready_q);

endmodule
